// File: rtl/argmax_stream_pkg.sv
// Shared state encoding and the ordering rule used by both the lane tree and the running merge.
package argmax_stream_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // True when a strictly beats b; signed order is an unsigned compare with the MSB flipped.
  function automatic logic better(input logic [63:0] a, input logic [63:0] b,
                                  input int w, input int sgn, input int mn);
    logic [63:0] ka;
    logic [63:0] kb;
    ka = a;
    kb = b;
    if (sgn != 0) begin
      ka[w-1] = ~ka[w-1];
      kb[w-1] = ~kb[w-1];
    end
    return (mn != 0) ? (ka < kb) : (ka > kb);
  endfunction

endpackage

// File: rtl/argmax_tree.sv
// Combinational lane reduction of one beat to (value, lane); on equality the lower lane wins.
module argmax_tree
  import argmax_stream_pkg::*;
#(
  parameter int M      = 8,
  parameter int LOG2L  = 2,
  parameter int SIGNED = 0,
  parameter int MIN    = 0,
  localparam int L     = 2 ** LOG2L,
  localparam int LW    = (LOG2L > 0) ? LOG2L : 1
) (
  input  logic [L*M-1:0] data_i,
  output logic [M-1:0]   val_o,
  output logic [LW-1:0]  lane_o
);

  // Heap layout: node n has children 2n+1 (lower lanes) and 2n+2; leaves sit at L-1..2L-2.
  logic [M-1:0]  nval  [2*L-1];
  logic [LW-1:0] nlane [2*L-1];

  for (genvar i = 0; i < L; i++) begin : g_leaf
    assign nval[L-1+i]  = data_i[i*M +: M];
    assign nlane[L-1+i] = LW'(i);
  end

  for (genvar n = 0; n < L - 1; n++) begin : g_node
    logic pick_r;
    assign pick_r   = better(64'(nval[2*n+2]), 64'(nval[2*n+1]), M, SIGNED, MIN);
    assign nval[n]  = pick_r ? nval[2*n+2]  : nval[2*n+1];
    assign nlane[n] = pick_r ? nlane[2*n+2] : nlane[2*n+1];
  end

  assign val_o  = nval[0];
  assign lane_o = nlane[0];

endmodule

// File: rtl/argmax_stream.sv
// Two-stage streaming argmax/argmin: stage 1 reduces a beat, stage 2 merges into the frame best.
// Result appears two cycles after the last beat and is held (input stalled) until accepted.
module argmax_stream
  import argmax_stream_pkg::*;
#(
  parameter int M      = 8,
  parameter int S      = 5,
  parameter int LOG2L  = 2,
  parameter int SIGNED = 0,
  parameter int MIN    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [(2**LOG2L)*M-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [M-1:0]            out_max,
  output logic [S-1:0]            out_ind,
  output logic                    out_overflow
);

  localparam int LW = (LOG2L > 0) ? LOG2L : 1;
  localparam int CW = S - LOG2L;

  state_t        state_q, state_d;
  logic          en_q;
  logic [CW-1:0] cnt_q;
  logic          fovf_q;

  logic          s1_vld_q, s1_last_q, s1_ovf_q;
  logic [M-1:0]  s1_val_q;
  logic [S-1:0]  s1_ind_q;

  logic [M-1:0]  best_val_q;
  logic [S-1:0]  best_ind_q;
  logic          best_ovf_q, first_q;

  logic [M-1:0]  t_val;
  logic [LW-1:0] t_lane;
  logic          take, ovf_now, s1_done, replace;
  logic [S-1:0]  beat_ind;

  argmax_tree #(.M(M), .LOG2L(LOG2L), .SIGNED(SIGNED), .MIN(MIN)) u_tree (
    .data_i (in_data),
    .val_o  (t_val),
    .lane_o (t_lane)
  );

  // Input closes as soon as the last beat is in flight, not only once HOLD is reached.
  assign s1_done  = s1_vld_q && s1_last_q;
  assign in_ready = en_q && (state_q == ACCUM) && !s1_done;
  assign take     = in_valid && in_ready;
  assign ovf_now  = fovf_q | ((&cnt_q) & ~in_last);
  assign beat_ind = (S'(cnt_q) << LOG2L) | S'(t_lane);
  assign replace  = s1_vld_q &&
                    (first_q || better(64'(s1_val_q), 64'(best_val_q), M, SIGNED, MIN));

  assign out_valid    = (state_q == HOLD);
  assign out_max      = best_val_q;
  assign out_ind      = best_ind_q;
  assign out_overflow = best_ovf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (s1_done)   state_d = HOLD;
      HOLD:    if (out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCUM;
      en_q       <= 1'b0;
      cnt_q      <= '0;
      fovf_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_ovf_q   <= 1'b0;
      s1_val_q   <= '0;
      s1_ind_q   <= '0;
      best_val_q <= '0;
      best_ind_q <= '0;
      best_ovf_q <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      en_q     <= 1'b1;
      s1_vld_q <= take;
      if (take) begin
        s1_val_q  <= t_val;
        s1_ind_q  <= beat_ind;
        s1_last_q <= in_last;
        s1_ovf_q  <= ovf_now;
        if (in_last) begin
          cnt_q  <= '0;
          fovf_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_q + CW'(1);
          fovf_q <= ovf_now;
        end
      end
      if (replace) begin
        best_val_q <= s1_val_q;
        best_ind_q <= s1_ind_q;
      end
      // Overflow is sticky in stage 1, so the last beat's flag is the frame's flag.
      if (s1_vld_q) begin
        best_ovf_q <= s1_ovf_q;
        first_q    <= s1_last_q;
      end
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Directed bench for argmax_stream: unsigned-max and signed-min instances share one input stream.
module tb_argmax_stream;

  logic        clk, rst, in_valid, in_last, out_ready;
  logic [31:0] in_data;
  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [7:0]  a_out_max;
  logic [4:0]  a_out_ind;
  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [7:0]  b_out_max;
  logic [4:0]  b_out_ind;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] fr [64];

  argmax_stream #(.M(8), .S(5), .LOG2L(2), .SIGNED(0), .MIN(0)) u_max (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready), .out_max(a_out_max),
    .out_ind(a_out_ind), .out_overflow(a_out_ovf)
  );

  argmax_stream #(.M(8), .S(5), .LOG2L(2), .SIGNED(1), .MIN(1)) u_smin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready), .out_max(b_out_max),
    .out_ind(b_out_ind), .out_overflow(b_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat(input int b);
    return {fr[4*b+3], fr[4*b+2], fr[4*b+1], fr[4*b]};
  endfunction

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send(input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!a_in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("in_ready_wait", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input int nb, input int bmax, input bit with_last);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, bmax)) @(negedge clk);
      send(beat(b), with_last && (b == nb - 1));
    end
  endtask

  task automatic finish_frame(input logic [7:0] ea, input logic [4:0] ia,
                              input logic [7:0] eb, input logic [4:0] ib,
                              input logic eo, input int delay, input bit accept);
    chk("lat_early_vld", 32'(a_out_valid), 32'd0);
    chk("lat_early_rdy", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    chk("lat_vld_a", 32'(a_out_valid), 32'd1);
    chk("lat_vld_b", 32'(b_out_valid), 32'd1);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("bp_rdy", 32'(a_in_ready), 32'd0);
      chk("bp_vld", 32'(a_out_valid), 32'd1);
      chk("bp_max", 32'(a_out_max), 32'(ea));
      chk("bp_ind", 32'(a_out_ind), 32'(ia));
    end
    chk("a_max", 32'(a_out_max), 32'(ea));
    chk("a_ind", 32'(a_out_ind), 32'(ia));
    chk("a_ovf", 32'(a_out_ovf), 32'(eo));
    chk("b_max", 32'(b_out_max), 32'(eb));
    chk("b_ind", 32'(b_out_ind), 32'(ib));
    chk("b_ovf", 32'(b_out_ovf), 32'(eo));
    if (accept) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("acc_vld", 32'(a_out_valid), 32'd0);
      chk("acc_rdy", 32'(a_in_ready), 32'd1);
    end
  endtask

  task automatic model(input int n, output logic [7:0] am, output logic [4:0] ai,
                       output logic [7:0] bm, output logic [4:0] bi);
    am = fr[0]; ai = 5'd0; bm = fr[0]; bi = 5'd0;
    for (int i = 1; i < n; i++) begin
      if (fr[i] > am) begin am = fr[i]; ai = 5'(i); end
      if ($signed(fr[i]) < $signed(bm)) begin bm = fr[i]; bi = 5'(i); end
    end
  endtask

  initial begin
    logic [7:0] am, bm;
    logic [4:0] ai, bi;
    int nb;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rdy", 32'(a_in_ready), 32'd0);
    chk("rst_vld", 32'(a_out_valid), 32'd0);
    chk("rst_max", 32'(a_out_max), 32'd0);
    chk("rst_ind", 32'(a_out_ind), 32'd0);
    chk("rst_ovf", 32'(a_out_ovf), 32'd0);
    rst = 1'b0;
    #1 chk("rel_rdy_same_cycle", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    chk("rel_rdy", 32'(a_in_ready), 32'd1);

    // 1: single 99 at index 13
    for (int i = 0; i < 32; i++) fr[i] = 8'(i);
    fr[13] = 8'd99;
    send_beats(8, 0, 1'b1);
    finish_frame(8'd99, 5'd13, 8'd0, 5'd0, 1'b0, 0, 1'b1);

    // 2: ties
    for (int i = 0; i < 32; i++) fr[i] = 8'd42;
    send_beats(8, 1, 1'b1);
    finish_frame(8'd42, 5'd0, 8'd42, 5'd0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 32; i++) fr[i] = 8'd0;
    fr[5] = 8'd42; fr[22] = 8'd42;
    send_beats(8, 0, 1'b1);
    finish_frame(8'd42, 5'd5, 8'd0, 5'd0, 1'b0, 0, 1'b1);

    // 3 + 4: signed extreme at index 30, then held under backpressure
    for (int i = 0; i < 32; i++) fr[i] = 8'h7f;
    fr[30] = 8'h80;
    send_beats(8, 0, 1'b1);
    finish_frame(8'h80, 5'd30, 8'h80, 5'd30, 1'b0, 5, 1'b0);
    fr[0] = 8'd5; fr[1] = 8'd9; fr[2] = 8'd9; fr[3] = 8'd2;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = beat(0); in_last = 1'b1;
    chk("bypass_rdy", 32'(a_in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bypass_vld", 32'(a_out_valid), 32'd0);
    chk("bypass_rdy_next", 32'(a_in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    finish_frame(8'd9, 5'd1, 8'd2, 5'd3, 1'b0, 0, 1'b1);

    // 5: overflow, 10 beats, max at index 39 -> 7
    for (int i = 0; i < 40; i++) fr[i] = 8'(i);
    send_beats(10, 0, 1'b1);
    finish_frame(8'd39, 5'd7, 8'd0, 5'd0, 1'b1, 0, 1'b1);
    for (int i = 0; i < 32; i++) fr[i] = 8'(i);
    fr[13] = 8'd99;
    send_beats(8, 0, 1'b1);
    finish_frame(8'd99, 5'd13, 8'd0, 5'd0, 1'b0, 0, 1'b1);

    // 6: reset mid-frame
    for (int i = 0; i < 12; i++) fr[i] = 8'(200 + i);
    send_beats(3, 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(a_in_ready), 32'd0);
    chk("mid_rst_max", 32'(a_out_max), 32'd0);
    chk("mid_rst_ind", 32'(a_out_ind), 32'd0);
    chk("mid_rst_vld", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_rdy", 32'(a_in_ready), 32'd1);
    fr[0] = 8'd3; fr[1] = 8'd7; fr[2] = 8'd7; fr[3] = 8'd1;
    send_beats(1, 0, 1'b1);
    finish_frame(8'd7, 5'd1, 8'd1, 5'd3, 1'b0, 0, 1'b1);

    // Random frames against the behavioural model
    for (int f = 0; f < 300; f++) begin
      nb = int'($urandom_range(1, 10));
      for (int i = 0; i < 4 * nb; i++)
        fr[i] = (f % 2 == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      model(4 * nb, am, ai, bm, bi);
      send_beats(nb, 2, 1'b1);
      finish_frame(am, ai, bm, bi, nb > 8, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
